// File: rtl/debounce_bank.sv
// Four-channel push-button debouncer: one sync flop per button, then a level is
// accepted only after LIMIT consecutive disagreeing edges. Emits a per-channel change strobe.

module debounce_ch #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic out_o,
    output logic chg_o
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e         state;
    logic           sync_q, sync_d;
    logic           out_q, out_d;
    logic           chg_q, chg_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // State is implied by the sync/out disagreement, so no separate state flop.
    always_comb begin
        state  = (sync_q != out_q) ? PENDING : STABLE;
        sync_d = btn_i;
        cnt_d  = '0;
        out_d  = out_q;
        chg_d  = 1'b0;
        case (state)
            PENDING: begin
                if (cnt_q == TERM) begin
                    out_d = sync_q;
                    chg_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            chg_q  <= chg_d;
        end
    end

    assign out_o = out_q;
    assign chg_o = chg_q;
endmodule

module debounce_bank #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnHS,
    input  logic       btnVS,
    input  logic       btnDF_UART,
    input  logic       btnDF_VGA,
    output logic       HS,
    output logic       VS,
    output logic       DF_UART,
    output logic       DF_VGA,
    output logic [3:0] chg
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] btn;
    logic [NUM_LANES-1:0] lvl;

    assign btn = {btnDF_VGA, btnDF_UART, btnVS, btnHS};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
        debounce_ch #(.LIMIT(LIMIT)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .btn_i (btn[g]),
            .out_o (lvl[g]),
            .chg_o (chg[g])
        );
    end

    assign HS      = lvl[0];
    assign VS      = lvl[1];
    assign DF_UART = lvl[2];
    assign DF_VGA  = lvl[3];
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: a LIMIT=4 instance and a LIMIT=1 instance
// sharing clock and reset, each with its own button vector.

module tb_debounce_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] b4 = 4'b0000;
    logic [3:0] b1 = 4'b0000;
    logic       hs4, vs4, du4, dv4;
    logic       hs1, vs1, du1, dv1;
    logic [3:0] chg4, chg1;
    logic [3:0] lv4, lv1;
    int         n_chk = 0;
    int         n_fail = 0;

    assign lv4 = {dv4, du4, vs4, hs4};
    assign lv1 = {dv1, du1, vs1, hs1};

    always #5 clk = ~clk;

    debounce_bank #(.LIMIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .btnHS(b4[0]), .btnVS(b4[1]), .btnDF_UART(b4[2]), .btnDF_VGA(b4[3]),
        .HS(hs4), .VS(vs4), .DF_UART(du4), .DF_VGA(dv4), .chg(chg4)
    );

    debounce_bank #(.LIMIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .btnHS(b1[0]), .btnVS(b1[1]), .btnDF_UART(b1[2]), .btnDF_VGA(b1[3]),
        .HS(hs1), .VS(vs1), .DF_UART(du1), .DF_VGA(dv1), .chg(chg1)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        b4 = 4'b1111;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (lv4 !== 4'b0000) begin n_fail++; $display("FAIL rst_lvl got=%b exp=%b", lv4, 4'b0000); end
        n_chk++; if (chg4 !== 4'b0000) begin n_fail++; $display("FAIL rst_chg got=%b exp=%b", chg4, 4'b0000); end
        n_chk++; if (lv1 !== 4'b0000) begin n_fail++; $display("FAIL rst_lvl1 got=%b exp=%b", lv1, 4'b0000); end
        b4 = 4'b0001;
        rst_n = 1'b1;
        tick(4);
        n_chk++; if (lv4 !== 4'b0000) begin n_fail++; $display("FAIL rst_hs_e5 got=%b exp=%b", lv4, 4'b0000); end
        n_chk++; if (chg4 !== 4'b0000) begin n_fail++; $display("FAIL rst_chg_e5 got=%b exp=%b", chg4, 4'b0000); end
        tick(1);
        n_chk++; if (lv4 !== 4'b0001) begin n_fail++; $display("FAIL rst_hs_e6 got=%b exp=%b", lv4, 4'b0001); end
        n_chk++; if (chg4 !== 4'b0001) begin n_fail++; $display("FAIL rst_chg_e6 got=%b exp=%b", chg4, 4'b0001); end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_chk++; if (lv4 !== 4'b0001 || chg4 !== 4'b0000) begin
                n_fail++; $display("FAIL hold_hs[%0d] got lvl=%b chg=%b exp lvl=0001 chg=0000", i, lv4, chg4);
            end
        end
    endtask

    task automatic test_glitch;
        b4[1] = 1'b1;
        tick(3);
        b4[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            n_chk++; if (lv4 !== 4'b0001 || chg4 !== 4'b0000) begin
                n_fail++; $display("FAIL glitch_vs[%0d] got lvl=%b chg=%b exp lvl=0001 chg=0000", i, lv4, chg4);
            end
        end
        b4[1] = 1'b1;
        tick(4);
        n_chk++; if (lv4 !== 4'b0001) begin n_fail++; $display("FAIL vs_early got=%b exp=%b", lv4, 4'b0001); end
        tick(1);
        n_chk++; if (lv4 !== 4'b0011) begin n_fail++; $display("FAIL vs_rise got=%b exp=%b", lv4, 4'b0011); end
        n_chk++; if (chg4 !== 4'b0010) begin n_fail++; $display("FAIL vs_chg got=%b exp=%b", chg4, 4'b0010); end
        tick(1);
        n_chk++; if (chg4 !== 4'b0000) begin n_fail++; $display("FAIL vs_chg_clr got=%b exp=%b", chg4, 4'b0000); end
    endtask

    task automatic test_release;
        logic [6:0] pat;
        int         ups;
        pat = 7'b0000101;
        ups = 0;
        b4[2] = 1'b1;
        tick(5);
        n_chk++; if (lv4 !== 4'b0111 || chg4 !== 4'b0100) begin
            n_fail++; $display("FAIL du_rise got lvl=%b chg=%b exp lvl=0111 chg=0100", lv4, chg4);
        end
        tick(1);
        b4[2] = 1'b0;
        tick(4);
        n_chk++; if (lv4 !== 4'b0111) begin n_fail++; $display("FAIL du_fall_early got=%b exp=%b", lv4, 4'b0111); end
        tick(1);
        n_chk++; if (lv4 !== 4'b0011 || chg4 !== 4'b0100) begin
            n_fail++; $display("FAIL du_fall got lvl=%b chg=%b exp lvl=0011 chg=0100", lv4, chg4);
        end
        tick(1);
        n_chk++; if (chg4 !== 4'b0000) begin n_fail++; $display("FAIL du_fall_clr got=%b exp=%b", chg4, 4'b0000); end
        b4[2] = 1'b1;
        tick(6);
        n_chk++; if (lv4 !== 4'b0111) begin n_fail++; $display("FAIL du_rearm got=%b exp=%b", lv4, 4'b0111); end
        for (int i = 0; i < 7; i++) begin
            b4[2] = pat[i];
            tick(1);
            ups += int'(chg4[2]);
            n_chk++; if (du4 !== 1'b1 || chg4[2] !== 1'b0) begin
                n_fail++; $display("FAIL bounce[%0d] got du=%b chg=%b exp du=1 chg=0", i, du4, chg4[2]);
            end
        end
        b4[2] = 1'b0;
        tick(1);
        ups += int'(chg4[2]);
        n_chk++; if (du4 !== 1'b0 || chg4[2] !== 1'b1) begin
            n_fail++; $display("FAIL bounce_fall got du=%b chg=%b exp du=0 chg=1", du4, chg4[2]);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            ups += int'(chg4[2]);
        end
        n_chk++; if (ups != 1) begin n_fail++; $display("FAIL bounce_updates got=%0d exp=1", ups); end
        n_chk++; if (lv4 !== 4'b0011) begin n_fail++; $display("FAIL bounce_final got=%b exp=%b", lv4, 4'b0011); end
    endtask

    task automatic test_back_to_back;
        rst_n = 1'b0;
        b4 = 4'b0000;
        #1;
        n_chk++; if (lv4 !== 4'b0000 || chg4 !== 4'b0000) begin
            n_fail++; $display("FAIL async_rst got lvl=%b chg=%b exp 0000/0000", lv4, chg4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        b4 = 4'b1111;
        tick(4);
        n_chk++; if (lv4 !== 4'b0000) begin n_fail++; $display("FAIL sim_early got=%b exp=%b", lv4, 4'b0000); end
        tick(1);
        n_chk++; if (lv4 !== 4'b1111) begin n_fail++; $display("FAIL sim_rise got=%b exp=%b", lv4, 4'b1111); end
        n_chk++; if (chg4 !== 4'b1111) begin n_fail++; $display("FAIL sim_chg got=%b exp=%b", chg4, 4'b1111); end
        tick(1);
        n_chk++; if (chg4 !== 4'b0000) begin n_fail++; $display("FAIL sim_chg_clr got=%b exp=%b", chg4, 4'b0000); end
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        b4 = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        b4[3] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        n_chk++; if (lv4 !== 4'b0000 || chg4 !== 4'b0000) begin
            n_fail++; $display("FAIL mid_rst got lvl=%b chg=%b exp 0000/0000", lv4, chg4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        n_chk++; if (lv4 !== 4'b0000) begin n_fail++; $display("FAIL mid_early got=%b exp=%b", lv4, 4'b0000); end
        tick(1);
        n_chk++; if (lv4 !== 4'b1000 || chg4 !== 4'b1000) begin
            n_fail++; $display("FAIL mid_rise got lvl=%b chg=%b exp lvl=1000 chg=1000", lv4, chg4);
        end
    endtask

    task automatic test_limit1;
        logic prev;
        prev = 1'b0;
        for (int k = 0; k < 10; k++) begin
            b1[0] = (k % 2 == 0);
            tick(1);
            if (k == 0) begin
                n_chk++; if (lv1 !== 4'b0000 || chg1 !== 4'b0000) begin
                    n_fail++; $display("FAIL l1_first got lvl=%b chg=%b exp 0000/0000", lv1, chg1);
                end
            end else begin
                n_chk++; if (lv1 !== {3'b000, prev} || chg1 !== 4'b0001) begin
                    n_fail++; $display("FAIL l1_tog[%0d] got lvl=%b chg=%b exp lvl=%b chg=0001", k, lv1, chg1, {3'b000, prev});
                end
            end
            prev = b1[0];
        end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_release;
        test_back_to_back;
        test_reset_mid;
        test_limit1;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Four-channel button debouncer that turns raw push-button levels (btnHS, btnVS, btnDF_UART, btnDF_VGA) into clean, glitch-free control levels (HS, VS, DF_UART, DF_VGA) for the display and UART data-flow logic. It sits between the board button pins and the control path. Each channel synchronises its button with one flop, then accepts a new level only after the synchronised value has differed from the current output for LIMIT consecutive clock edges. The same consumers also get a one-cycle change strobe per channel.

## Interface
- LIMIT, default 4: number of consecutive edges the synchronised button must disagree with the output before the output changes; legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btnHS  input  1  raw button, channel 0.
- btnVS  input  1  raw button, channel 1.
- btnDF_UART  input  1  raw button, channel 2.
- btnDF_VGA  input  1  raw button, channel 3.
- HS  output  1  debounced level, channel 0.
- VS  output  1  debounced level, channel 1.
- DF_UART  output  1  debounced level, channel 2.
- DF_VGA  output  1  debounced level, channel 3.
- chg  output  4  one-cycle strobe; bit i is high in the cycle after channel i's output changed. Bit order is [0]=HS, [1]=VS, [2]=DF_UART, [3]=DF_VGA.

## Operation
- Channels are independent and identical; there is no shared state.
- Per-channel registers:
  - sync: 1 bit, captures the raw button on every edge.
  - cnt: width $clog2(LIMIT), saturating never (it is cleared before it can overflow).
  - out: drives the debounced output.
  - chg bit.
- Two-state machine per channel:
  - STABLE (sync == out): cnt <= 0; out holds.
  - PENDING (sync != out) with cnt < LIMIT-1: cnt <= cnt+1.
  - PENDING with cnt == LIMIT-1: out <= sync, cnt <= 0, chg bit <= 1.
  - Returning to STABLE before terminal count is glitch rejection: cnt clears, out unchanged, no strobe.
- The chg bit is cleared on every edge where the channel does not update.
- LIMIT = 1: out follows sync one edge later; every change pulses chg.
- Reset (asynchronous, any time, including mid-count): sync, cnt, out, chg all go to 0 immediately.
  - Reset values: HS=VS=DF_UART=DF_VGA=0, chg=4'b0000.
  - A pending count is discarded. Counting restarts from the first rising edge with rst_n high.
- Simultaneous qualifying changes on several channels all update in the same cycle; chg may have several bits set.

## Timing
- Let the raw button be sampled at value v on LIMIT consecutive rising edges e0..e(LIMIT-1), with out != v before e0.
  - out changes on edge e(LIMIT).
  - The new value is observable at sample edge e(LIMIT+1).
  - out must still hold the old value when sampled at e(LIMIT).
- The chg bit is high exactly one cycle, from e(LIMIT) to e(LIMIT+1).
- A raw level held for LIMIT-1 or fewer consecutive edges never reaches the output.
- If the button stays at v for longer than LIMIT edges, out stays at v and chg stays 0.
- Every window of LIMIT consecutive identical samples must therefore be followed, two edges after the window's last sample, by out equal to that value. This holds for both 0 and 1, on all four channels.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset check (LIMIT=4): assert rst_n=0 with all buttons at 1 -> all outputs 0, chg=0. Release and hold btnHS=1 -> HS=1 sampled at the 6th edge after release, not at the 5th; chg[0]=1 for that cycle only.
- Glitch rejection: btnVS high for 3 edges, then low -> VS stays 0 and chg stays 0. Then high for 4 edges -> VS=1 two edges after the 4th high sample.
- Release path: with DF_UART=1, btnDF_UART low for 4 edges -> DF_UART=0 two edges later and chg[2] pulses once. A bounce pattern of 1,0,1,0,0,0,0 -> exactly one falling update, aligned to the last four lows.
- Simultaneous channels: all four buttons rise on the same edge and hold -> all outputs rise in the same cycle, chg=4'b1111 for one cycle.
- Reset mid-operation: btnDF_VGA high for 3 edges, pulse rst_n low, then hold high -> DF_VGA rises 5 edges after the first post-reset edge (the count restarts), not earlier.
- LIMIT=1 build: toggle btnHS every edge -> HS reproduces the pattern delayed by 2 edges and chg[0] is high every cycle.
